pwr_single_domain_out_fifo: RTL and testbench

// - Output buffer downstream of the single-domain fixed-latency data pipeline.
// - Absorbs the pipeline's non-stallable word stream and presents it to the consumer over a valid/ready handshake.
// - Counts and flags words lost on overflow.
// - Sits entirely in the same always-on power domain as the pipeline: no isolation, retention or level shifting.

---
 rtl/pwr_single_domain_out_fifo.sv | 79 +++++++
 tb/tb_pwr_single_domain_out_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pwr_single_domain_out_fifo.sv
// pwr_single_domain_out_fifo: output buffer for a non-stallable pipeline, presented over valid/ready
// with a registered head, a sticky overflow flag and a saturating drop counter.
module pwr_single_domain_out_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic             w_pop, w_push, w_drop;
    logic [AW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_pop      = (r_count != '0) && out_ready;
    assign w_push     = in_valid && ((r_count < CW'(DEPTH)) || w_pop);
    assign w_drop     = in_valid && !w_push;
    assign w_rd_nxt   = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    // The next head may be the word being written this very cycle (empty, or one left after a pop).
    assign w_head_nxt = (w_push && r_wr_ptr == w_rd_nxt) ? in_data : r_mem[w_rd_nxt];

    always_ff @(posedge clk)
        if (w_push && !clr) r_mem[r_wr_ptr] <= in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'h00;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'h00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            if (w_cnt_nxt != '0) r_out_data <= w_head_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'h01;
            end
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_data    = r_out_data;
    assign count       = r_count;
    assign almost_full = (r_count >= CW'(AFULL_LVL));
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_pwr_single_domain_out_fifo.sv
// tb_pwr_single_domain_out_fifo: directed and random stimulus checked against a queue-based model
// of the output FIFO.
module tb_pwr_single_domain_out_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic       almost_full;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    int         m_drop = 0;
    logic [7:0] m_last = 8'h00;

    pwr_single_domain_out_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AFULL_LVL(3)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count),
        .almost_full(almost_full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("count", 32'(count), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("out_data", 32'(out_data), 32'(m_last));
        check("almost_full", 32'(almost_full), 32'(q.size() >= 3));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic c);
        logic pop, push;
        in_valid = iv; in_data = d; out_ready = ordy; clr = c;
        @(posedge clk);
        if (c) begin
            q.delete(); m_ovf = 1'b0; m_drop = 0;
        end else begin
            pop  = (q.size() != 0) && ordy;
            push = iv && (q.size() < DEPTH || pop);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
            else if (iv) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (q.size() != 0) m_last = q[0];
        @(negedge clk);
        check_model();
    endtask

    task automatic model_reset();
        q.delete(); m_ovf = 1'b0; m_drop = 0; m_last = 8'h00;
    endtask

    initial begin
        // reset state
        model_reset();
        @(negedge clk); @(negedge clk);
        check_model();
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        // 1: three pushes, no pop
        step(1'b1, 8'h11, 1'b0, 1'b0);
        check("t1_latency", 32'(out_data), 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check("t1_count", 32'(count), 32'd3);
        check("t1_afull", 32'(almost_full), 32'd1);
        check("t1_head", 32'(out_data), 32'h11);
        check("t1_ovf", 32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        // 2: fill then overflow, then drain
        for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_drop", 32'(drop_cnt), 32'd1);
        check("t2_count", 32'(count), 32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_stable", 32'(out_data), 32'hA0);
        for (int i = 0; i < 4; i++) begin
            check("t2_drain", 32'(out_data), 32'hA0 + 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("t2_empty", 32'(out_valid), 32'd0);
        check("t2_hold", 32'(out_data), 32'hA3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_empty_ready", 32'(count), 32'd0);
        // 3: full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        check("t3_count", 32'(count), 32'd4);
        check("t3_head", 32'(out_data), 32'hC1);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        // 4: streaming from empty; each word appears the cycle after its push
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            check("t4_stream", 32'(out_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        // 5: saturate drop counter, then clr with a word presented
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("t5_sat", 32'(drop_cnt), 32'hFF);
        check("t5_ovf", 32'(overflow), 32'd1);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        check("t5_clr_count", 32'(count), 32'd0);
        check("t5_clr_ovf", 32'(overflow), 32'd0);
        check("t5_clr_drop", 32'(drop_cnt), 32'd0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 60) == 0));
        // 6: asynchronous reset between edges with two words stored
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hE1, 1'b0, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b0);
        check("t6_pre", 32'(count), 32'd2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_data", 32'(out_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check("t6_first", 32'(out_data), 32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_after", 32'(out_valid), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
